// File: rtl/seg7_mux_decoder_pkg.sv
// rtl/seg7_mux_decoder_pkg.sv - segment patterns and FSM states shared by the 7-segment bus reader
package seg7_mux_decoder_pkg;

  // Patterns as emitted by the display driver, active-high {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;

  localparam logic [3:0] TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - segment pattern to BCD digit, with tens-phase range check
module seg7_decode
  import seg7_mux_decoder_pkg::*;
(
  input  logic [6:0] an,
  input  logic       tens_phase,
  output logic [3:0] digit,
  output logic       legal
);

  logic known;

  always_comb begin
    digit = 4'd0;
    known = 1'b1;
    case (an)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: known = 1'b0;
    endcase
    // Tens digit of a minute:second display never exceeds 5
    legal = known && (!tens_phase || (digit <= TENS_MAX));
  end

endmodule

// File: rtl/seg7_mux_decoder.sv
// rtl/seg7_mux_decoder.sv - reads a 2-digit multiplexed 7-segment bus back into a BCD pair
module seg7_mux_decoder
  import seg7_mux_decoder_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 125_000_000,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CA,
  input  logic [6:0] AN,
  output logic [3:0] NUM_1S,
  output logic [2:0] NUM_10S,
  output logic       VALID,
  output logic       ERR,
  output logic       STALE
);

  localparam int unsigned SETTLE_EFF = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  // An unusable timeout falls back to roughly 1 ms of CLK
  localparam int unsigned TO_LIMIT   = (TIMEOUT_CYC > SETTLE_EFF) ? TIMEOUT_CYC : CLK_FREQ / 1000;
  localparam int          SETTLE_W   = $clog2(SETTLE_EFF + 1);
  localparam int          TO_W       = $clog2(TO_LIMIT + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_EFF - 1);
  localparam logic [TO_W-1:0]     TO_MAX      = TO_W'(TO_LIMIT);
  localparam logic [TO_W-1:0]     TO_PRE      = TO_W'(TO_LIMIT - 1);

  logic       ca_m, ca_s, ca_d;
  logic [6:0] an_m, an_s, an_d;
  logic       ca_edge, an_stable;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ca_m <= 1'b0;
      ca_s <= 1'b0;
      ca_d <= 1'b0;
      an_m <= 7'd0;
      an_s <= 7'd0;
      an_d <= 7'd0;
    end else begin
      ca_m <= CA;
      ca_s <= ca_m;
      ca_d <= ca_s;
      an_m <= AN;
      an_s <= an_m;
      an_d <= an_s;
    end
  end

  assign ca_edge   = (ca_s != ca_d);
  assign an_stable = (an_s == an_d);

  logic [TO_W-1:0] to_cnt;
  logic            stale_q;
  logic            timeout_hit;

  assign timeout_hit = !ca_edge && (to_cnt == TO_PRE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      to_cnt  <= '0;
      stale_q <= 1'b1;
    end else if (ca_edge) begin
      to_cnt  <= '0;
      stale_q <= 1'b0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 1'b1;
      if (timeout_hit) stale_q <= 1'b1;
    end
  end

  assign STALE = stale_q;

  state_t              state_q, state_n;
  logic [SETTLE_W-1:0] settle_q, settle_n;
  logic                phase_q, phase_n;
  logic                capture, abort;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_WAIT;
      settle_q <= '0;
      phase_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      settle_q <= settle_n;
      phase_q  <= phase_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    settle_n = settle_q;
    phase_n  = phase_q;
    capture  = 1'b0;
    abort    = 1'b0;
    if (timeout_hit) begin
      state_n  = S_WAIT;
      settle_n = '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (ca_edge) begin
            state_n  = S_SETTLE;
            phase_n  = ca_s;
            settle_n = '0;
          end
        end
        S_SETTLE: begin
          if (ca_edge) begin
            // Phase ended before the segments settled; its data is unusable
            abort    = 1'b1;
            phase_n  = ca_s;
            settle_n = '0;
          end else if (!an_stable) begin
            settle_n = '0;
          end else if (settle_q == SETTLE_LAST) begin
            capture  = 1'b1;
            state_n  = S_HOLD;
            settle_n = '0;
          end else begin
            settle_n = settle_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (ca_edge) begin
            state_n  = S_SETTLE;
            phase_n  = ca_s;
            settle_n = '0;
          end
        end
        default: begin
          state_n  = S_WAIT;
          settle_n = '0;
        end
      endcase
    end
  end

  logic [3:0] dec_digit;
  logic       dec_legal;

  seg7_decode u_decode (
    .an         (an_s),
    .tens_phase (phase_q),
    .digit      (dec_digit),
    .legal      (dec_legal)
  );

  logic [3:0] pend;
  logic       pend_vld;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      NUM_1S   <= 4'd0;
      NUM_10S  <= 3'd0;
      VALID    <= 1'b0;
      ERR      <= 1'b0;
      pend     <= 4'd0;
      pend_vld <= 1'b0;
    end else begin
      VALID <= 1'b0;
      ERR   <= 1'b0;
      if (timeout_hit || abort) begin
        pend_vld <= 1'b0;
      end else if (capture) begin
        if (!dec_legal) begin
          ERR      <= 1'b1;
          pend_vld <= 1'b0;
        end else if (!phase_q) begin
          pend     <= dec_digit;
          pend_vld <= 1'b1;
        end else if (pend_vld) begin
          NUM_1S   <= pend;
          NUM_10S  <= dec_digit[2:0];
          VALID    <= 1'b1;
          pend_vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_mux_decoder.sv
// tb/tb_seg7_mux_decoder.sv - scoreboard bench for seg7_mux_decoder
module tb_seg7_mux_decoder;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CA;
  logic [6:0] AN;
  logic [3:0] NUM_1S;
  logic [2:0] NUM_10S;
  logic       VALID;
  logic       ERR;
  logic       STALE;

  int cyc     = 0;
  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit is_err;
    int n1;
    int n10;
    int issue;
  } exp_t;

  exp_t sb[$];

  seg7_mux_decoder #(
    .CLK_FREQ    (125_000_000),
    .SETTLE_CYC  (4),
    .TIMEOUT_CYC (1000)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .CA      (CA),
    .AN      (AN),
    .NUM_1S  (NUM_1S),
    .NUM_10S (NUM_10S),
    .VALID   (VALID),
    .ERR     (ERR),
    .STALE   (STALE)
  );

  always #4 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endtask

  task automatic drive(input logic ca_v, input logic [6:0] an_v, input int n);
    CA = ca_v;
    AN = an_v;
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_pulse(input bit is_err, input int n1, input int n10);
    exp_t e;
    e.is_err = is_err;
    e.n1     = n1;
    e.n10    = n10;
    e.issue  = cyc;
    sb.push_back(e);
  endtask

  // Monitor: every VALID/ERR pulse must match the next queued expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && (VALID || ERR)) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", int'({VALID, ERR}), 0);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", int'({VALID, ERR}), e.is_err ? 1 : 2);
          chk("num_1s", int'(NUM_1S), e.n1);
          chk("num_10s", int'(NUM_10S), e.n10);
          chk("latency", cyc - e.issue, 7);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    RST = 1'b1;
    CA  = 1'b0;
    AN  = 7'h00;
    repeat (3) @(negedge CLK);
    chk("rst_num_1s", int'(NUM_1S), 0);
    chk("rst_num_10s", int'(NUM_10S), 0);
    chk("rst_valid", int'(VALID), 0);
    chk("rst_err", int'(ERR), 0);
    chk("rst_stale", int'(STALE), 1);
    RST = 1'b0;

    // 1: first tens phase after reset has no partner; then 9/5 pair
    drive(1'b0, 7'h7E, 125);
    drive(1'b1, 7'h5B, 125);
    drive(1'b0, 7'h7E, 2);
    drive(1'b0, 7'h7B, 123);
    expect_pulse(1'b0, 9, 5);
    drive(1'b1, 7'h5B, 125);

    // 2: tens pattern 6 is illegal, outputs hold 9/5, then recovery 2/4
    drive(1'b0, 7'h30, 125);
    expect_pulse(1'b1, 9, 5);
    drive(1'b1, 7'h5F, 125);
    chk("err_hold_1s", int'(NUM_1S), 9);
    chk("err_hold_10s", int'(NUM_10S), 5);
    drive(1'b0, 7'h6D, 125);
    expect_pulse(1'b0, 2, 4);
    drive(1'b1, 7'h33, 125);

    // 3: 2-cycle glitch just before settle would complete
    drive(1'b0, 7'h30, 3);
    drive(1'b0, 7'h7F, 2);
    drive(1'b0, 7'h79, 120);
    expect_pulse(1'b0, 3, 4);
    drive(1'b1, 7'h33, 125);

    // 4: timeout with a pending ones digit
    CA = 1'b0;
    AN = 7'h7F;
    repeat (1002) @(negedge CLK);
    chk("stale_before_timeout", int'(STALE), 0);
    @(negedge CLK);
    chk("stale_at_timeout", int'(STALE), 1);
    repeat (7) @(negedge CLK);
    CA = 1'b1;
    AN = 7'h5B;
    repeat (2) @(negedge CLK);
    chk("stale_until_edge", int'(STALE), 1);
    @(negedge CLK);
    chk("stale_cleared", int'(STALE), 0);
    repeat (122) @(negedge CLK);
    drive(1'b0, 7'h7E, 125);
    expect_pulse(1'b0, 0, 1);
    drive(1'b1, 7'h30, 125);

    // 5: short phases clear pending ones, following tens is dropped
    drive(1'b0, 7'h79, 125);
    drive(1'b1, 7'h6D, 2);
    drive(1'b0, 7'h7E, 2);
    drive(1'b1, 7'h6D, 125);
    drive(1'b0, 7'h30, 125);
    expect_pulse(1'b0, 1, 2);
    drive(1'b1, 7'h6D, 125);

    // 6: asynchronous reset while settling a tens phase
    drive(1'b0, 7'h79, 125);
    CA = 1'b1;
    AN = 7'h30;
    repeat (4) @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    chk("async_rst_num_1s", int'(NUM_1S), 0);
    chk("async_rst_num_10s", int'(NUM_10S), 0);
    chk("async_rst_valid", int'(VALID), 0);
    chk("async_rst_err", int'(ERR), 0);
    chk("async_rst_stale", int'(STALE), 1);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (125) @(negedge CLK);
    chk("post_rst_num_1s", int'(NUM_1S), 0);
    chk("post_rst_num_10s", int'(NUM_10S), 0);
    chk("post_rst_stale", int'(STALE), 0);
    drive(1'b0, 7'h5F, 125);
    expect_pulse(1'b0, 6, 3);
    drive(1'b1, 7'h79, 125);

    repeat (10) @(negedge CLK);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
